// File: rtl/wb_bot_poller_pkg.sv
// Shared definitions for the rojobot Wishbone poller.
// Register offsets, sequencer states and classic-cycle constants.
package wb_bot_poller_pkg;

   localparam logic [31:0] OFF_INFO = 32'h0000_000C;
   localparam logic [31:0] OFF_CTRL = 32'h0000_0010;
   localparam logic [31:0] OFF_SYNC = 32'h0000_0014;
   localparam logic [31:0] OFF_IACK = 32'h0000_0018;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POLL,
      S_GAP,
      S_INFO,
      S_CTRL,
      S_ASET,
      S_ACLR,
      S_FAULT
   } state_t;

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic read or write with hold-until-ack,
// drop-after-ack and a cycle timeout.
module wb_single_xfer #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic        we,
   input  logic [31:0] adr,
   input  logic [31:0] wdat,
   output logic [31:0] rdat,
   output logic        done,
   output logic        fault,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);
   import wb_bot_poller_pkg::*;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

   logic [15:0] tcnt;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wb_cyc_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         rdat     <= '0;
         done     <= 1'b0;
         fault    <= 1'b0;
         tcnt     <= '0;
      end else begin
         done  <= 1'b0;
         fault <= 1'b0;
         if (wb_cyc_o) begin
            // err takes priority over a simultaneous ack
            if (wb_err_i) begin
               wb_cyc_o <= 1'b0;
               fault    <= 1'b1;
            end else if (wb_ack_i) begin
               wb_cyc_o <= 1'b0;
               rdat     <= wb_dat_i;
               done     <= 1'b1;
            end else if (tcnt == TO_LAST) begin
               wb_cyc_o <= 1'b0;
               fault    <= 1'b1;
            end else begin
               tcnt <= tcnt + 16'd1;
            end
         end else if (start) begin
            wb_cyc_o <= 1'b1;
            wb_we_o  <= we;
            wb_adr_o <= adr;
            wb_dat_o <= wdat;
            tcnt     <= '0;
         end
      end
   end

endmodule

// File: rtl/wb_bot_poller.sv
// Hardware rojobot handshake: poll sync, read BotInfo,
// write motor control, then set and clear INT_ACK.
module wb_bot_poller #(
   parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
   parameter int          POLL_GAP    = 16,
   parameter int          TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        enable,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_data,
   output logic [31:0] bot_info,
   output logic        info_valid,
   output logic        busy,
   output logic        bus_fault,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic [2:0]  wb_cti_o,
   output logic [1:0]  wb_bte_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);
   import wb_bot_poller_pkg::*;

   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

   state_t      state;
   logic        issued;
   logic        start;
   logic [7:0]  gap_cnt;
   logic [7:0]  cmd_reg;
   logic        x_we;
   logic [31:0] x_adr;
   logic [31:0] x_wdat;
   logic [31:0] rdat;
   logic        done;
   logic        fault;

   assign busy     = (state != S_IDLE);
   assign wb_stb_o = wb_cyc_o;
   assign wb_sel_o = 4'b0001;
   assign wb_cti_o = CTI_CLASSIC;
   assign wb_bte_o = BTE_LINEAR;

   always_comb begin
      x_we   = 1'b0;
      x_adr  = BASE_ADR | OFF_SYNC;
      x_wdat = '0;
      unique case (state)
         S_INFO: x_adr = BASE_ADR | OFF_INFO;
         S_CTRL: begin
            x_we   = 1'b1;
            x_adr  = BASE_ADR | OFF_CTRL;
            x_wdat = {24'h0, cmd_reg};
         end
         S_ASET: begin
            x_we   = 1'b1;
            x_adr  = BASE_ADR | OFF_IACK;
            x_wdat = 32'h1;
         end
         S_ACLR: begin
            x_we   = 1'b1;
            x_adr  = BASE_ADR | OFF_IACK;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) cmd_reg <= 8'h00;
      else if (cmd_valid) cmd_reg <= cmd_data;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         issued     <= 1'b0;
         start      <= 1'b0;
         gap_cnt    <= '0;
         bot_info   <= '0;
         info_valid <= 1'b0;
         bus_fault  <= 1'b0;
      end else begin
         start      <= 1'b0;
         info_valid <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (enable && !bus_fault) begin
                  state  <= S_POLL;
                  issued <= 1'b0;
               end
            end
            S_GAP: begin
               if (!enable) begin
                  state <= S_IDLE;
               end else if (gap_cnt == GAP_LAST) begin
                  state   <= S_POLL;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            S_FAULT: begin
               if (!enable) begin
                  state     <= S_IDLE;
                  bus_fault <= 1'b0;
               end
            end
            default: begin
               if (!issued) begin
                  start  <= 1'b1;
                  issued <= 1'b1;
               end else if (fault) begin
                  state     <= S_FAULT;
                  bus_fault <= 1'b1;
                  issued    <= 1'b0;
               end else if (done) begin
                  issued <= 1'b0;
                  unique case (state)
                     S_POLL: begin
                        gap_cnt <= '0;
                        if (!enable)     state <= S_IDLE;
                        else if (rdat[0]) state <= S_INFO;
                        else             state <= S_GAP;
                     end
                     S_INFO: begin
                        bot_info   <= rdat;
                        info_valid <= 1'b1;
                        state      <= S_CTRL;
                     end
                     S_CTRL: state <= S_ASET;
                     S_ASET: state <= S_ACLR;
                     default: state <= enable ? S_POLL : S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   wb_single_xfer #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_xfer (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .we       (x_we),
      .adr      (x_adr),
      .wdat     (x_wdat),
      .rdat     (rdat),
      .done     (done),
      .fault    (fault),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_we_o  (wb_we_o),
      .wb_cyc_o (wb_cyc_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .wb_err_i (wb_err_i)
   );

endmodule

// File: tb/tb_wb_bot_poller.sv
// Bench for wb_bot_poller with a register-model responder
// and a scoreboard of expected bus transactions.
module tb_wb_bot_poller;
   import wb_bot_poller_pkg::*;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam int PG = 16;
   localparam int TO = 10;

   logic        clk, rstn, enable, cmd_valid;
   logic [7:0]  cmd_data;
   logic [31:0] bot_info;
   logic        info_valid, busy, bus_fault;
   logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
   logic [3:0]  wb_sel_o;
   logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
   logic [2:0]  wb_cti_o;
   logic [1:0]  wb_bte_o;

   wb_bot_poller #(
      .BASE_ADR(BASE), .POLL_GAP(PG), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .enable(enable),
      .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .bot_info(bot_info), .info_valid(info_valid),
      .busy(busy), .bus_fault(bus_fault),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
      .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
      .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
      .wb_err_i(wb_err_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic        err;
      int          t;
   } tr_t;

   typedef struct {
      logic [31:0] info;
      logic [7:0]  cmd;
      int          mode;
      logic [31:0] exp_info;
      logic [31:0] exp_ctrl;
   } vec_t;

   tr_t exp_q[$];
   tr_t obs_arr[0:511];
   int  obs_wr = 0;
   int  obs_rd = 0;
   int  tests = 0;
   int  fails = 0;

   // responder controls (main thread) and monitor state
   int          mode = 0;
   int          sync_target = 0;
   logic [31:0] info_val = '0;
   int          iack_cnt = 0;
   int          cyc_n = 0;
   int          sync_reads = 0;
   int          last_sync = -1;
   int          min_space = 1000000;
   int          dup_ack = 0;
   int          iv_cnt = 0;
   int          iv_long = 0;
   int          run = 0;
   int          last_run = 0;
   logic [31:0] last_info = '0;
   logic        prev_hit = 1'b0;
   logic        prev_iv = 1'b0;
   logic        sync_bit;

   assign sync_bit = (iack_cnt < sync_target);

   // mode 0 normal, 1 ack held while cyc, 2 never ack, 3 err on IACK
   always @(posedge clk) begin
      logic hit, is_err;
      if (!rstn) begin
         wb_ack_i <= 1'b0;
         wb_err_i <= 1'b0;
         wb_dat_i <= '0;
      end else begin
         hit = wb_cyc_o && wb_stb_o;
         if (mode == 2) hit = 1'b0;
         else if (mode != 1) hit = hit && !wb_ack_i && !wb_err_i;
         is_err = (mode == 3) && wb_we_o && (wb_adr_o[7:0] == OFF_IACK[7:0]);
         wb_ack_i <= hit && !is_err;
         wb_err_i <= hit && is_err;
         if (wb_adr_o[7:0] == OFF_SYNC[7:0]) wb_dat_i <= {31'b0, sync_bit};
         else if (wb_adr_o[7:0] == OFF_INFO[7:0]) wb_dat_i <= info_val;
         else wb_dat_i <= 32'hDEAD_BEEF;
      end
   end

   always @(negedge clk) begin
      cyc_n++;
      if (wb_cyc_o && (wb_ack_i || wb_err_i)) begin
         if (!wb_we_o && wb_adr_o == (BASE | OFF_SYNC)) begin
            if (last_sync >= 0 && cyc_n - last_sync < min_space)
               min_space = cyc_n - last_sync;
            last_sync = cyc_n;
            sync_reads++;
         end else if (obs_wr < 512) begin
            obs_arr[obs_wr] = '{wb_we_o, wb_adr_o,
               wb_we_o ? wb_dat_o : wb_dat_i, wb_err_i, cyc_n};
            obs_wr++;
         end
         if (wb_we_o && wb_adr_o == (BASE | OFF_IACK) &&
             wb_dat_o == 32'h1 && !wb_err_i)
            iack_cnt++;
         if (prev_hit) dup_ack++;
         prev_hit = 1'b1;
      end else begin
         prev_hit = 1'b0;
      end
      if (info_valid) begin
         iv_cnt++;
         last_info = bot_info;
         if (prev_iv) iv_long++;
      end
      prev_iv = info_valid;
      if (wb_cyc_o) run++;
      else begin
         if (run != 0) last_run = run;
         run = 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push(input logic we, input logic [31:0] off,
                       input logic [31:0] dat, input logic err);
      exp_q.push_back('{we, BASE | off, dat, err, 0});
   endtask

   task automatic push_pass(input logic [31:0] info, input logic [7:0] cmd);
      push(1'b0, OFF_INFO, info, 1'b0);
      push(1'b1, OFF_CTRL, {24'h0, cmd}, 1'b0);
      push(1'b1, OFF_IACK, 32'h1, 1'b0);
      push(1'b1, OFF_IACK, 32'h0, 1'b0);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_cmd(input logic [7:0] v);
      cmd_data  = v;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic drain(input string nm, input int budget);
      int  k;
      tr_t e, o;
      k = 0;
      while ((obs_wr - obs_rd) < exp_q.size() && k < budget) begin
         @(negedge clk);
         k++;
      end
      if ((obs_wr - obs_rd) < exp_q.size()) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got %0d transactions want %0d",
                  nm, obs_wr - obs_rd, exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (obs_rd < obs_wr) begin
            o = obs_arr[obs_rd];
            obs_rd++;
            chk({nm, ".we"},  32'(o.we),  32'(e.we));
            chk({nm, ".adr"}, o.adr, e.adr);
            chk({nm, ".dat"}, o.dat, e.dat);
            chk({nm, ".err"}, 32'(o.err), 32'(e.err));
         end
      end
   endtask

   task automatic wait_ctrl();
      int k;
      k = 0;
      while (!(wb_cyc_o && wb_we_o && wb_adr_o == (BASE | OFF_CTRL))
             && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("ctrl_seen", 32'(k < 400), 1);
   endtask

   vec_t vecs[4];
   int   iv0, base, s0, k;

   initial begin
      rstn = 1'b0; enable = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
      vecs[0] = '{32'h1234_5602, 8'h33, 0, 32'h1234_5602, 32'h33};
      vecs[1] = '{32'hA5A5_00FF, 8'h00, 0, 32'hA5A5_00FF, 32'h00};
      vecs[2] = '{32'hFFFF_FFFF, 8'hFF, 1, 32'hFFFF_FFFF, 32'hFF};
      vecs[3] = '{32'h0000_0001, 8'h80, 1, 32'h0000_0001, 32'h80};
      cycles(3);
      rstn = 1'b1;
      cycles(2);

      chk("rst_cyc", 32'(wb_cyc_o), 0);
      chk("rst_stb", 32'(wb_stb_o), 0);
      chk("rst_we", 32'(wb_we_o), 0);
      chk("rst_adr", wb_adr_o, 0);
      chk("rst_dat", wb_dat_o, 0);
      chk("rst_sel", 32'(wb_sel_o), 1);
      chk("rst_cti", 32'(wb_cti_o), 0);
      chk("rst_bte", 32'(wb_bte_o), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_fault", 32'(bus_fault), 0);
      chk("rst_iv", 32'(info_valid), 0);
      chk("rst_info", bot_info, 0);

      enable = 1'b1;
      cycles(130);
      chk("poll_count", 32'(sync_reads >= 4), 1);
      chk("poll_space", 32'(min_space >= PG + 3), 1);
      chk("poll_no_wr", 32'(obs_wr - obs_rd), 0);
      chk("poll_busy", 32'(busy), 1);
      chk("poll_fault", 32'(bus_fault), 0);

      for (int i = 0; i < 4; i++) begin
         mode = vecs[i].mode;
         info_val = vecs[i].info;
         load_cmd(vecs[i].cmd);
         push_pass(vecs[i].exp_info, vecs[i].exp_ctrl[7:0]);
         iv0 = iv_cnt;
         sync_target = iack_cnt + 1;
         drain($sformatf("vec%0d", i), 400);
         cycles(2);
         chk($sformatf("vec%0d.iv", i), 32'(iv_cnt - iv0), 1);
         chk($sformatf("vec%0d.last", i), last_info, vecs[i].exp_info);
         chk($sformatf("vec%0d.info", i), bot_info, vecs[i].exp_info);
      end
      chk("dup_ack", 32'(dup_ack), 0);
      chk("iv_width", 32'(iv_long), 0);
      mode = 0;
      cycles(5);

      info_val = 32'hCAFE_0003;
      base = obs_rd;
      push_pass(32'hCAFE_0003, 8'h80);
      push_pass(32'hCAFE_0003, 8'h80);
      sync_target = iack_cnt + 2;
      drain("again", 600);
      chk("again_nogap",
          32'(obs_arr[base + 4].t - obs_arr[base + 3].t < PG), 1);
      cycles(5);

      load_cmd(8'h11);
      info_val = 32'h0BAD_F00D;
      push_pass(32'h0BAD_F00D, 8'h11);
      sync_target = iack_cnt + 2;
      wait_ctrl();
      enable = 1'b0;
      cmd_data = 8'h55;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      drain("endrop", 400);
      s0 = sync_reads;
      cycles(40);
      chk("endrop_idle", 32'(busy), 0);
      chk("endrop_quiet", 32'(obs_wr - obs_rd), 0);
      chk("endrop_nopoll", 32'(sync_reads - s0), 0);

      info_val = 32'h7777_0000;
      push_pass(32'h7777_0000, 8'h55);
      sync_target = iack_cnt + 1;
      enable = 1'b1;
      drain("newcmd", 400);
      cycles(5);

      mode = 3;
      info_val = 32'h5555_AAAA;
      push(1'b0, OFF_INFO, 32'h5555_AAAA, 1'b0);
      push(1'b1, OFF_CTRL, 32'h55, 1'b0);
      push(1'b1, OFF_IACK, 32'h1, 1'b1);
      sync_target = iack_cnt + 1;
      drain("err", 400);
      cycles(30);
      chk("err_fault", 32'(bus_fault), 1);
      chk("err_busy", 32'(busy), 1);
      chk("err_cyc", 32'(wb_cyc_o), 0);
      chk("err_quiet", 32'(obs_wr - obs_rd), 0);
      enable = 1'b0;
      cycles(3);
      chk("err_clr", 32'(bus_fault), 0);
      chk("err_idle", 32'(busy), 0);
      mode = 0;
      sync_target = iack_cnt;

      mode = 2;
      enable = 1'b1;
      k = 0;
      while (!bus_fault && k < 200) begin
         @(negedge clk);
         k++;
      end
      cycles(2);
      chk("to_fault", 32'(bus_fault), 1);
      chk("to_len", 32'(last_run), TO);
      chk("to_cyc", 32'(wb_cyc_o), 0);
      enable = 1'b0;
      cycles(3);
      chk("to_clr", 32'(bus_fault), 0);
      chk("to_idle", 32'(busy), 0);
      mode = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
